ringbuffer_readout: RTL and testbench
=====================================

# ringbuffer_readout

Read-side controller for the ADC ring buffer. It captures the buffer write pointer on a trigger and lets post-trigger samples accumulate. It then freezes buffer writes and streams a fixed window of PRE pre-trigger and POST post-trigger samples out of the buffer over a valid/ready interface to the event packer. It drives the buffer's write gate, read enable and read address, and absorbs the buffer's 2-cycle read latency with a small output FIFO so downstream backpressure never loses a word.

## Interface
- SIZE, 10: buffer address width; buffer depth 2**SIZE.
- WIDTH, 14: sample width.
- PRE, 64: samples read before the trigger sample.
- POST, 192: samples read from the trigger sample onward, trigger sample included. PRE+POST must be ≤ 2**SIZE−1 and POST ≥ 1; checked at elaboration.

- sysclk  in  1  clock for everything.
- rst  in  1  reset, synchronous, active-high.
- adc_valid  in  1  ADC sample strobe.
- trigger  in  1  single-cycle trigger pulse.
- wr_addr  in  SIZE  buffer write pointer (next address to be written).
- rb_wr_en  out  1  buffer write enable = adc_valid gated by state.
- rb_rd_en  out  1  buffer read enable.
- rb_addr  out  SIZE  buffer read address.
- rb_dout  in  WIDTH  buffer read data; valid 2 cycles after rb_addr is presented with rb_rd_en high.
- m_data  out  WIDTH  output sample.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high with the final (PRE+POST-th) word.
- busy  out  1  high in any state other than IDLE.
- trig_dropped  out  1  one-cycle pulse when a trigger arrives while busy.

## Operation
- States: IDLE, POSTFILL, READ, DRAIN.
- IDLE: rb_wr_en = adc_valid. On trigger: latch A = wr_addr, set start = A − PRE (mod 2**SIZE), clear post count, go to POSTFILL. The write accepted in the trigger cycle is post sample 0 (address A).
- POSTFILL: rb_wr_en = adc_valid. Count accepted writes, including the trigger-cycle write. When the count reaches POST, gate rb_wr_en to 0 from the next cycle and go to READ.
- READ: rb_wr_en = 0 and rb_rd_en = 1.
  - Issue one address per cycle from start, incrementing modulo 2**SIZE.
  - An address issues only when fifo_count + inflight < 4.
  - After PRE+POST issues, go to DRAIN.
- DRAIN: rb_rd_en = 1 until in-flight reads have landed. Go to IDLE when the last word is accepted (m_valid & m_ready & m_last).
- A 2-stage valid shift register tracks in-flight reads. Arriving rb_dout words are pushed into a 4-entry FIFO, which drives m_data/m_valid.
- Output word k (0-based) is the sample at address start+k. m_last is asserted on k = PRE+POST−1.
- Triggers outside IDLE are ignored and pulse trig_dropped. A trigger in the same cycle the FSM returns to IDLE is dropped.
- Counters are SIZE+1 bits wide. Address arithmetic wraps at 2**SIZE with no special case at address 0.

## Timing
- Reset values:
  - rb_wr_en = adc_valid (IDLE); rb_rd_en = 0; rb_addr = 0.
  - m_valid = 0, m_last = 0, busy = 0, trig_dropped = 0.
  - FIFO empty, in-flight cleared, state IDLE.
- Reset mid-operation returns to IDLE next cycle, discards FIFO and in-flight data, and re-enables writes.
- Trigger at cycle T: busy = 1 from T+1.
- Last post write at cycle P: rb_wr_en = 0 from P+1.
- First rb_addr issue at P+1; first m_valid at P+3 or later.
- With m_ready held high, one word per cycle after the first, so total readout is PRE+POST+2 cycles after READ entry.
- m_data/m_valid/m_last hold stable while m_valid & !m_ready.
- Samples arriving while writes are gated are lost by design. Dead time = readout duration.

## Structure
- Shared package mmaps_pkg:
  - state enum {IDLE, POSTFILL, READ, DRAIN}.
  - RB_RD_LATENCY = 2, READOUT_FIFO_DEPTH = 4.
- One sub-module, readout_fifo: synchronous, depth 4, width WIDTH+1 (data plus last flag), synchronous reset, count output.

## Test plan
- Write ramp 0..1023 continuously (default params); trigger when wr_addr = 500 → 256 words 436..691, m_last on word 691, busy falls after handshake, rb_wr_en resumes.
- Trigger at wr_addr = 10 → words start at address 970 (wrap), data 970..1023 then 0..201; rb_addr wraps 1023→0 with no gap.
- Random m_ready (≈30% duty) during readout → identical sequence, no duplicate or lost word, m_data stable while stalled, FIFO never overflows.
- Second trigger during POSTFILL and during READ → trig_dropped pulses twice; captured window unaffected.
- rst asserted mid-READ after 100 words → next cycle m_valid = 0, busy = 0, rb_rd_en = 0. A new trigger then yields a clean full window.
- adc_valid toggling every other cycle in POSTFILL → exactly POST writes counted before the gate closes; sample at A read as word PRE.

Source files
------------

// File: rtl/mmaps_pkg.sv
// Shared definitions for the ADC ring-buffer readout path.
//   rb_state_t          readout controller states
//   RB_RD_LATENCY       cycles from rb_addr/rb_rd_en to valid rb_dout
//   READOUT_FIFO_DEPTH  words of output buffering behind the ring buffer
package mmaps_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      POSTFILL = 2'd1,
      READ     = 2'd2,
      DRAIN    = 2'd3
   } rb_state_t;

   localparam int RB_RD_LATENCY      = 2;
   localparam int READOUT_FIFO_DEPTH = 4;

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO that absorbs ring-buffer read latency against
// downstream backpressure.
//   sysclk, rst   clock, synchronous active-high reset
//   push, din     write side; a push into a full FIFO is ignored
//   pop           read side; dout/valid show the head entry
//   count         current occupancy
module readout_fifo
   import mmaps_pkg::*;
#(
   parameter int DW    = 15,
   parameter int DEPTH = READOUT_FIFO_DEPTH
) (
   input  logic                         sysclk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [DW-1:0]                din,
   input  logic                         pop,
   output logic [DW-1:0]                dout,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign valid   = (count != '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge sysclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ringbuffer_readout.sv
// Read-side controller for the ADC ring buffer. On trigger it captures the
// write pointer, lets POST samples accumulate, freezes writes and streams
// PRE pre-trigger plus POST post-trigger samples out over valid/ready.
//   sysclk, rst        clock, synchronous active-high reset
//   adc_valid          ADC sample strobe
//   trigger            single-cycle trigger pulse
//   wr_addr            buffer write pointer (next address written)
//   rb_wr_en           buffer write enable (adc_valid gated by state)
//   rb_rd_en, rb_addr  buffer read request
//   rb_dout            buffer read data, RB_RD_LATENCY cycles after request
//   m_data, m_valid, m_ready, m_last   output stream
//   busy               controller not idle
//   trig_dropped       pulse for a trigger arriving while busy
//
// state    | meaning
// IDLE     | writes enabled, waiting for trigger
// POSTFILL | writes enabled, counting post-trigger samples
// READ     | writes frozen, issuing window read addresses
// DRAIN    | all addresses issued, emptying pipeline and FIFO
module ringbuffer_readout
   import mmaps_pkg::*;
#(
   parameter int SIZE  = 10,
   parameter int WIDTH = 14,
   parameter int PRE   = 64,
   parameter int POST  = 192
) (
   input  logic             sysclk,
   input  logic             rst,
   input  logic             adc_valid,
   input  logic             trigger,
   input  logic [SIZE-1:0]  wr_addr,
   output logic             rb_wr_en,
   output logic             rb_rd_en,
   output logic [SIZE-1:0]  rb_addr,
   input  logic [WIDTH-1:0] rb_dout,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic             busy,
   output logic             trig_dropped
);

   if ((PRE + POST > 2**SIZE - 1) || (POST < 1)) begin : g_param_check
      $error("ringbuffer_readout: window PRE+POST must fit the buffer and POST must be >= 1");
   end

   localparam int              CW       = $clog2(READOUT_FIFO_DEPTH + 1);
   localparam logic [SIZE:0]   POST_N   = (SIZE+1)'(POST);
   localparam logic [SIZE:0]   LAST_IDX = (SIZE+1)'(PRE + POST - 1);

   rb_state_t                 state, state_nxt;
   logic [SIZE-1:0]           rd_addr;
   logic [SIZE:0]             post_cnt;
   logic [SIZE:0]             issue_cnt;
   logic [RB_RD_LATENCY-1:0]  pipe_v;
   logic [RB_RD_LATENCY-1:0]  pipe_last;
   logic [CW-1:0]             inflight;
   logic [CW-1:0]             fifo_count;
   logic [WIDTH:0]            fifo_dout;
   logic                      credit_ok;
   logic                      issue;
   logic                      issue_last;
   logic                      fifo_pop;

   // Issue only when every word already requested is guaranteed a FIFO slot.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RB_RD_LATENCY; i++) inflight = inflight + CW'(pipe_v[i]);
   end

   assign credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(READOUT_FIFO_DEPTH);
   assign issue_last = issue && (issue_cnt == LAST_IDX);
   assign fifo_pop   = m_valid && m_ready;

   always_comb begin
      state_nxt    = state;
      rb_wr_en     = 1'b0;
      rb_rd_en     = 1'b0;
      issue        = 1'b0;
      trig_dropped = trigger && (state != IDLE) && !rst;
      case (state)
         IDLE: begin
            rb_wr_en = adc_valid;
            if (trigger) state_nxt = (adc_valid && POST_N == 1) ? READ : POSTFILL;
         end
         POSTFILL: begin
            rb_wr_en = adc_valid;
            if (adc_valid && (post_cnt + 1'b1 == POST_N)) state_nxt = READ;
         end
         READ: begin
            rb_rd_en = 1'b1;
            issue    = credit_ok;
            if (issue_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            rb_rd_en = |pipe_v;
            if (fifo_pop && m_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state     <= IDLE;
         rd_addr   <= '0;
         post_cnt  <= '0;
         issue_cnt <= '0;
         pipe_v    <= '0;
         pipe_last <= '0;
      end else begin
         state     <= state_nxt;
         pipe_v    <= {pipe_v[RB_RD_LATENCY-2:0], issue};
         pipe_last <= {pipe_last[RB_RD_LATENCY-2:0], issue_last};
         case (state)
            IDLE: begin
               if (trigger) begin
                  rd_addr   <= wr_addr - SIZE'(PRE);
                  post_cnt  <= {{SIZE{1'b0}}, adc_valid};
                  issue_cnt <= '0;
               end
            end
            POSTFILL: begin
               if (adc_valid) post_cnt <= post_cnt + 1'b1;
            end
            READ: begin
               if (issue) begin
                  rd_addr   <= rd_addr + 1'b1;
                  issue_cnt <= issue_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   readout_fifo #(
      .DW    (WIDTH + 1),
      .DEPTH (READOUT_FIFO_DEPTH)
   ) u_fifo (
      .sysclk (sysclk),
      .rst    (rst),
      .push   (pipe_v[RB_RD_LATENCY-1]),
      .din    ({pipe_last[RB_RD_LATENCY-1], rb_dout}),
      .pop    (fifo_pop),
      .dout   (fifo_dout),
      .valid  (m_valid),
      .count  (fifo_count)
   );

   assign m_data  = fifo_dout[WIDTH-1:0];
   assign m_last  = m_valid && fifo_dout[WIDTH];
   assign rb_addr = rd_addr;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ringbuffer_readout.sv
// Directed bench for ringbuffer_readout: a behavioural ring buffer whose
// content at address a is always a, so every expected word is its address.
module tb_ringbuffer_readout;

   localparam int SIZE  = 10;
   localparam int WIDTH = 14;
   localparam int PRE   = 64;
   localparam int POST  = 192;
   localparam int TOT   = PRE + POST;

   logic             sysclk = 1'b0;
   logic             rst;
   logic             adc_valid;
   logic             trigger;
   logic [SIZE-1:0]  wr_addr = '0;
   logic             rb_wr_en;
   logic             rb_rd_en;
   logic [SIZE-1:0]  rb_addr;
   logic [WIDTH-1:0] rb_dout;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic             busy;
   logic             trig_dropped;

   int n_cmp = 0;
   int n_err = 0;

   always #5 sysclk = ~sysclk;

   ringbuffer_readout #(
      .SIZE (SIZE), .WIDTH (WIDTH), .PRE (PRE), .POST (POST)
   ) dut (
      .sysclk       (sysclk),
      .rst          (rst),
      .adc_valid    (adc_valid),
      .trigger      (trigger),
      .wr_addr      (wr_addr),
      .rb_wr_en     (rb_wr_en),
      .rb_rd_en     (rb_rd_en),
      .rb_addr      (rb_addr),
      .rb_dout      (rb_dout),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_last       (m_last),
      .busy         (busy),
      .trig_dropped (trig_dropped)
   );

   // Ring buffer model: ramp data equal to address, 2-cycle read latency.
   logic [WIDTH-1:0] mem [1024];
   logic [WIDTH-1:0] rd_p1 = '0;
   logic [WIDTH-1:0] rd_p2 = '0;
   assign rb_dout = rd_p2;

   always @(posedge sysclk) begin
      if (rb_wr_en) begin
         mem[wr_addr] <= WIDTH'(wr_addr);
         wr_addr      <= wr_addr + 1'b1;
      end
      if (rb_rd_en) rd_p1 <= mem[rb_addr];
      rd_p2 <= rd_p1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One trigger/readout event. a: trigger write pointer; pct: m_ready duty;
   // toggle: adc_valid alternates after trigger; abort_after: reset after
   // that many words (0 = none); extra: inject triggers in POSTFILL and READ.
   task automatic run_event(input int a, input int pct, input bit toggle,
                            input int abort_after, input bit extra,
                            input int exp_drops, input bit exp_wrap);
      int start, k, wr_cnt, drop_cnt;
      bit got, done, stalled, wrap_seen, paddr_ok, fired2, aborted;
      logic [WIDTH-1:0] pdata;
      logic             plast;
      logic [SIZE-1:0]  paddr;

      start = (a - PRE) & 1023;
      got = 0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge sysclk);
         trigger = 0; adc_valid = 1; m_ready = 1;
         if (wr_addr == SIZE'(a)) got = 1;
      end
      check_val("wait_addr", got, 1);

      trigger = 1; adc_valid = 1;
      #1;
      wr_cnt   = int'(rb_wr_en);
      drop_cnt = int'(trig_dropped);
      k = 0; done = 0; stalled = 0; wrap_seen = 0; paddr_ok = 0;
      fired2 = 0; aborted = 0; pdata = '0; plast = 0; paddr = '0;

      for (int cyc = 1; cyc < 4000 && !done; cyc++) begin
         @(negedge sysclk);
         trigger = 0;
         if (cyc == 1) check_val("busy_t1", busy, 1);
         if (abort_after > 0 && k == abort_after) begin
            rst = 1;
            @(negedge sysclk);
            check_val("rst_m_valid", m_valid, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_rd_en", rb_rd_en, 0);
            check_val("rst_wr_en", rb_wr_en, adc_valid);
            rst = 0;
            aborted = 1;
            break;
         end
         if (toggle) adc_valid = ~adc_valid;
         if (extra && cyc == 3) trigger = 1;
         if (extra && k == 20 && !fired2) begin
            trigger = 1;
            fired2  = 1;
         end
         m_ready = ($urandom_range(99) < pct);
         #1;
         wr_cnt   += int'(rb_wr_en);
         drop_cnt += int'(trig_dropped);
         if (stalled) begin
            check_val("stall_valid", m_valid, 1);
            check_val("stall_data", m_data, pdata);
            check_val("stall_last", m_last, plast);
         end
         if (rb_rd_en) begin
            if (paddr_ok && paddr == 10'd1023 && rb_addr == 10'd0) wrap_seen = 1;
            paddr    = rb_addr;
            paddr_ok = 1;
         end
         if (m_valid && m_ready) begin
            check_val("word", m_data, (start + k) & 1023);
            check_val("last", m_last, (k == TOT - 1));
            if (k == PRE) check_val("word_pre", m_data, a);
            if (m_last) done = 1;
            k++;
         end
         stalled = m_valid && !m_ready;
         pdata   = m_data;
         plast   = m_last;
      end

      if (!aborted) begin
         check_val("done", done, 1);
         check_val("word_count", k, TOT);
         check_val("wr_count", wr_cnt, POST);
         check_val("drops", drop_cnt, exp_drops);
         if (exp_wrap) check_val("addr_wrap", wrap_seen, 1);
         adc_valid = 1;
         @(negedge sysclk);
         check_val("busy_end", busy, 0);
         check_val("wr_resume", rb_wr_en, 1);
         check_val("valid_end", m_valid, 0);
      end
   endtask

   initial begin
      rst = 1; adc_valid = 1; trigger = 0; m_ready = 0;
      repeat (2) @(negedge sysclk);
      check_val("reset_wr_en", rb_wr_en, 1);
      check_val("reset_rd_en", rb_rd_en, 0);
      check_val("reset_addr", rb_addr, 0);
      check_val("reset_valid", m_valid, 0);
      check_val("reset_last", m_last, 0);
      check_val("reset_busy", busy, 0);
      check_val("reset_drop", trig_dropped, 0);
      rst = 0;

      repeat (1030) @(negedge sysclk);

      run_event(500, 100, 0, 0,   0, 0, 0);
      run_event(10,  100, 0, 0,   0, 0, 1);
      run_event(300, 30,  0, 0,   1, 2, 0);
      run_event(700, 100, 0, 100, 0, 0, 0);
      run_event(50,  100, 0, 0,   0, 0, 0);
      run_event(900, 100, 1, 0,   0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
